hrange_arbiter: RTL and testbench

HRANGE_ARBITER -- requirements
Module: hrange_arbiter

---
 rtl/hrange_arbiter.sv | 113 +++++++++++
 tb/tb_hrange_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrange_arbiter.sv
// hrange_arbiter: two-requester round-robin front end for one shared
// range generator; the winner's beats stream through combinationally.
module hrange_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic                    _clock,
   input  logic                    _reset,
   input  logic                    r0__req,
   input  logic                    r1__req,
   input  logic signed [WIDTH-1:0] r0_base,
   input  logic signed [WIDTH-1:0] r0_limit,
   input  logic signed [WIDTH-1:0] r0_step,
   input  logic signed [WIDTH-1:0] r1_base,
   input  logic signed [WIDTH-1:0] r1_limit,
   input  logic signed [WIDTH-1:0] r1_step,
   input  logic                    r0__ready,
   input  logic                    r1__ready,
   output logic                    r0__valid,
   output logic                    r1__valid,
   output logic signed [WIDTH-1:0] r0__0,
   output logic signed [WIDTH-1:0] r1__0,
   output logic                    r0__done,
   output logic                    r1__done,
   output logic                    gen__start,
   output logic                    gen__reset,
   output logic signed [WIDTH-1:0] gen_base,
   output logic signed [WIDTH-1:0] gen_limit,
   output logic signed [WIDTH-1:0] gen_step,
   output logic                    gen__ready,
   input  logic                    gen__valid,
   input  logic                    gen__done,
   input  logic signed [WIDTH-1:0] gen__0,
   output logic                    grant,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

   state_t                  state;
   logic                    last;
   logic                    pick;
   logic                    stream;
   logic                    sel_ready;
   logic                    take0;
   logic                    take1;
   logic signed [WIDTH-1:0] hold0;
   logic signed [WIDTH-1:0] hold1;

   assign stream     = (state == STREAM);
   assign sel_ready  = grant ? r1__ready : r0__ready;
   assign gen__ready = stream & sel_ready;
   assign r0__valid  = stream & ~grant & gen__valid;
   assign r1__valid  = stream & grant & gen__valid;
   assign r0__0      = (stream & ~grant) ? gen__0 : hold0;
   assign r1__0      = (stream & grant) ? gen__0 : hold1;
   assign take0      = r0__valid & r0__ready;
   assign take1      = r1__valid & r1__ready;

   // With both asking, whoever was not served last goes next.
   assign pick = r0__req ? (r1__req & ~last) : 1'b1;

   always_ff @(posedge _clock) begin
      gen__reset <= _reset;
      if (_reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         grant      <= 1'b0;
         gen__start <= 1'b0;
         r0__done   <= 1'b0;
         r1__done   <= 1'b0;
         gen_base   <= '0;
         gen_limit  <= '0;
         gen_step   <= '0;
         hold0      <= '0;
         hold1      <= '0;
         last       <= 1'b1;
      end else begin
         r0__done <= 1'b0;
         r1__done <= 1'b0;
         if (take0) hold0 <= gen__0;
         if (take1) hold1 <= gen__0;
         unique case (state)
            IDLE: begin
               if (r0__req | r1__req) begin
                  grant      <= pick;
                  busy       <= 1'b1;
                  gen__start <= 1'b1;
                  gen_base   <= pick ? r1_base : r0_base;
                  gen_limit  <= pick ? r1_limit : r0_limit;
                  gen_step   <= pick ? r1_step : r0_step;
                  state      <= START;
               end
            end
            // A previously finished generator still shows done here.
            START: begin
               gen__start <= 1'b0;
               state      <= STREAM;
            end
            STREAM: begin
               if (gen__done & ~gen__valid) begin
                  r0__done <= ~grant;
                  r1__done <= grant;
                  busy     <= 1'b0;
                  last     <= grant;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hrange_arbiter.sv
// Bench for hrange_arbiter: behavioural generator, transaction-level
// reference model, vector table, directed corners and random traffic.
module tb_hrange_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic r0_req, r1_req, r0_ready, r1_ready;
   logic signed [31:0] r0_base, r0_limit, r0_step;
   logic signed [31:0] r1_base, r1_limit, r1_step;
   logic r0_valid, r1_valid, r0_done, r1_done;
   logic signed [31:0] r0_0, r1_0;
   logic gen_start, gen_reset, gen_ready, gen_valid, gen_done;
   logic signed [31:0] gen_base, gen_limit, gen_step, gen_0;
   logic grant, busy;

   always #5 clk = ~clk;

   hrange_arbiter #(.WIDTH(32)) dut (
      ._clock(clk), ._reset(rst),
      .r0__req(r0_req), .r1__req(r1_req),
      .r0_base(r0_base), .r0_limit(r0_limit), .r0_step(r0_step),
      .r1_base(r1_base), .r1_limit(r1_limit), .r1_step(r1_step),
      .r0__ready(r0_ready), .r1__ready(r1_ready),
      .r0__valid(r0_valid), .r1__valid(r1_valid),
      .r0__0(r0_0), .r1__0(r1_0),
      .r0__done(r0_done), .r1__done(r1_done),
      .gen__start(gen_start), .gen__reset(gen_reset),
      .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
      .gen__ready(gen_ready), .gen__valid(gen_valid),
      .gen__done(gen_done), .gen__0(gen_0),
      .grant(grant), .busy(busy)
   );

   int n_tests = 0;
   int n_fail = 0;

   // generator model
   int gq[$];
   bit early = 1'b0;

   // reference model
   bit   m_busy = 1'b0;
   int   m_age = 0;
   bit   m_g = 1'b0;
   bit   m_last = 1'b1;
   bit   m_rst_q = 1'b1;
   bit   m_done[2] = '{1'b0, 1'b0};
   int   m_a[3] = '{0, 0, 0};
   int   m_hold[2] = '{0, 0};
   int   m_beats[2] = '{0, 0};
   int   eq[$];
   int   calls = 0;

   typedef struct {
      bit k;
      int b;
      int l;
      int s;
      bit early;
      int nb;
      int lat;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic gen_drive();
      gen_valid = (gq.size() > 0);
      gen_0     = (gq.size() > 0) ? gq[0] : 0;
      gen_done  = early ? (gq.size() <= 1) : (gq.size() == 0);
   endtask

   task automatic model_cycle();
      bit strm;
      bit rdy;
      int v;
      logic [31:0] got;
      strm = m_busy && m_age >= 1;
      rdy  = m_g ? r1_ready : r0_ready;
      chk("busy", busy, m_busy);
      if (m_busy) begin
         chk("grant", grant, m_g);
         chk("gen_base", gen_base, m_a[0]);
         chk("gen_limit", gen_limit, m_a[1]);
         chk("gen_step", gen_step, m_a[2]);
      end
      chk("gen_start", gen_start, m_busy && m_age == 0);
      chk("r0_done", r0_done, m_done[0]);
      chk("r1_done", r1_done, m_done[1]);
      chk("gen_reset", gen_reset, m_rst_q);
      chk("gen_ready", gen_ready, strm && rdy);
      chk("r0_valid", r0_valid, strm && !m_g && gen_valid);
      chk("r1_valid", r1_valid, strm && m_g && gen_valid);
      if (!(strm && !m_g)) chk("r0_hold", r0_0, m_hold[0]);
      if (!(strm && m_g)) chk("r1_hold", r1_0, m_hold[1]);
      if (strm && gen_valid && rdy) begin
         got = m_g ? r1_0 : r0_0;
         chk("beat_pending", eq.size() > 0, 1);
         v = 0;
         if (eq.size() > 0) v = eq.pop_front();
         chk("beat", got, v);
         m_hold[m_g] = v;
         m_beats[m_g]++;
      end
      m_done[0] = 1'b0;
      m_done[1] = 1'b0;
      m_rst_q = rst;
      if (rst) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         m_hold[0] = 0;
         m_hold[1] = 0;
         eq.delete();
      end else if (!m_busy) begin
         if (r0_req || r1_req) begin
            if (r0_req && r1_req) m_g = (m_last == 1'b0);
            else m_g = r1_req;
            if (m_g) m_a = '{r1_base, r1_limit, r1_step};
            else m_a = '{r0_base, r0_limit, r0_step};
            m_busy = 1'b1;
            m_age = 0;
            calls++;
            eq.delete();
            for (int x = m_a[0]; x < m_a[1]; x += m_a[2]) eq.push_back(x);
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (gen_done && !gen_valid) begin
         chk("beats_left", eq.size(), 0);
         m_done[m_g] = 1'b1;
         m_busy = 1'b0;
         m_last = m_g;
      end
   endtask

   task automatic tick();
      bit hs, st, rs;
      int b, l, s;
      @(negedge clk);
      model_cycle();
      hs = gen_valid && gen_ready;
      st = gen_start;
      rs = gen_reset;
      b = gen_base;
      l = gen_limit;
      s = gen_step;
      @(posedge clk);
      #1;
      if (rs) begin
         gq.delete();
      end else if (st) begin
         gq.delete();
         if (s > 0)
            for (int x = b; x < l; x += s) gq.push_back(x);
      end else if (hs && gq.size() > 0) begin
         void'(gq.pop_front());
      end
      gen_drive();
   endtask

   task automatic set_args(input bit k, input int b, input int l,
                           input int s);
      if (k) begin
         r1_base = b; r1_limit = l; r1_step = s;
      end else begin
         r0_base = b; r0_limit = l; r0_step = s;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_start", gen_start, 0);
      chk("rst_base", gen_base, 0);
      chk("rst_limit", gen_limit, 0);
      chk("rst_step", gen_step, 0);
      chk("rst_r0_0", r0_0, 0);
      chk("rst_r1_0", r1_0, 0);
      chk("rst_r0_done", r0_done, 0);
      chk("rst_r1_done", r1_done, 0);
      chk("rst_gen_reset", gen_reset, 1);
      rst = 1'b0;
   endtask

   task automatic wait_start();
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         tick();
         seen = gen_start;
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk("start_seen", seen, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk("idle_reached", busy, 0);
   endtask

   task automatic run_call(input bit k, input int b, input int l,
                           input int s, output int nb, output int lat);
      int n0, cnt;
      bit seen;
      n0 = m_beats[k];
      lat = -1;
      seen = 1'b0;
      cnt = 0;
      set_args(k, b, l, s);
      if (k) r1_req = 1'b1;
      else r0_req = 1'b1;
      for (int i = 0; i < 300 && lat < 0; i++) begin
         tick();
         if (seen) begin
            cnt++;
            if (k ? r1_done : r0_done) lat = cnt;
         end else if (gen_start) begin
            seen = 1'b1;
            r0_req = 1'b0;
            r1_req = 1'b0;
         end
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      nb = m_beats[k] - n0;
   endtask

   initial begin
      bit rr_exp[3];
      int rr_base[3];
      bit bp[4];
      int nb, lat, cnt, n0;

      vt[0] = '{1'b0, 0, 10, 2, 1'b0, 5, 7};
      vt[1] = '{1'b0, 3, 3, 1, 1'b0, 0, 2};
      vt[2] = '{1'b1, -4, 2, 3, 1'b0, 2, 4};
      vt[3] = '{1'b1, 5, 8, 1, 1'b1, 3, 5};
      vt[4] = '{1'b0, -10, -7, 1, 1'b0, 3, 5};
      rr_exp = '{1'b0, 1'b1, 1'b0};
      rr_base = '{100, 200, 100};
      bp = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      r0_req = 1'b0; r1_req = 1'b0;
      r0_ready = 1'b1; r1_ready = 1'b1;
      set_args(1'b0, 0, 0, 1);
      set_args(1'b1, 0, 0, 1);
      gen_drive();
      repeat (2) @(posedge clk);
      #1;

      // round robin with both requests held from reset
      set_args(1'b0, 100, 102, 1);
      set_args(1'b1, 200, 201, 1);
      r0_req = 1'b1;
      r1_req = 1'b1;
      apply_reset();
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         tick();
         if (gen_start) begin
            chk("rr_grant", grant, rr_exp[cnt]);
            chk("rr_base", gen_base, rr_base[cnt]);
            cnt++;
         end
      end
      chk("rr_calls", cnt, 3);
      r0_req = 1'b0;
      r1_req = 1'b0;
      wait_idle();
      tick();

      // vector table of single calls
      for (int i = 0; i < 5; i++) begin
         early = vt[i].early;
         run_call(vt[i].k, vt[i].b, vt[i].l, vt[i].s, nb, lat);
         chk($sformatf("vec%0d_beats", i), nb, vt[i].nb);
         chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
         tick();
      end
      early = 1'b0;

      // backpressure on r1
      r1_ready = 1'b0;
      set_args(1'b1, 5, 8, 1);
      r1_req = 1'b1;
      wait_start();
      tick();
      n0 = m_beats[1];
      for (int i = 0; i < 30 && busy; i++) begin
         r1_ready = (i < 4) ? bp[i] : 1'b1;
         tick();
      end
      chk("bp_beats", m_beats[1] - n0, 3);
      chk("bp_idle", busy, 0);
      r1_ready = 1'b1;
      tick();

      // done raised while the last beat is still pending
      early = 1'b1;
      r0_ready = 1'b0;
      set_args(1'b0, 0, 2, 1);
      r0_req = 1'b1;
      wait_start();
      tick();
      r0_ready = 1'b1;
      tick();
      r0_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dv_busy", busy, 1);
         chk("dv_nodone", r0_done, 0);
      end
      r0_ready = 1'b1;
      tick();
      chk("dv_accept_busy", busy, 1);
      chk("dv_accept_nodone", r0_done, 0);
      tick();
      chk("dv_done", r0_done, 1);
      chk("dv_idle", busy, 0);
      early = 1'b0;
      tick();

      // reset in the middle of a stream
      set_args(1'b0, 0, 20, 1);
      r0_req = 1'b1;
      wait_start();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", busy, 0);
      chk("mr_gen_reset", gen_reset, 1);
      chk("mr_nodone", r0_done, 0);
      tick();
      chk("mr_gen_reset_low", gen_reset, 0);
      chk("mr_nodone2", r0_done, 0);
      run_call(1'b1, 1, 3, 1, nb, lat);
      chk("mr_next_beats", nb, 2);
      chk("mr_next_latency", lat, 4);
      tick();

      // random traffic against the reference model
      n0 = calls;
      for (int i = 0; i < 4000; i++) begin
         int b;
         r0_req = ($urandom_range(0, 3) == 0);
         r1_req = ($urandom_range(0, 3) == 0);
         r0_ready = ($urandom_range(0, 3) != 0);
         r1_ready = ($urandom_range(0, 3) != 0);
         if (!busy) early = $urandom_range(0, 1);
         b = int'($urandom_range(0, 40)) - 20;
         set_args(1'b0, b, b + int'($urandom_range(0, 10)) - 1,
                  int'($urandom_range(1, 3)));
         b = int'($urandom_range(0, 40)) - 20;
         set_args(1'b1, b, b + int'($urandom_range(0, 10)) - 1,
                  int'($urandom_range(1, 3)));
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      r0_req = 1'b0;
      r1_req = 1'b0;
      r0_ready = 1'b1;
      r1_ready = 1'b1;
      wait_idle();
      tick();
      chk("rand_calls", (calls - n0) > 20, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
